// File: rtl/pool_window_sequencer.sv
// Pooling-pass sequencer: walks the input feature map window by window, frames the
// samples for the pooling unit and writes pooled results to consecutive output addresses.
module pool_window_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int DIM_WIDTH   = 8,
    parameter int WINDOW_SIZE = 2,
    parameter int STRIDE      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  cfg_width,
    input  logic [DIM_WIDTH-1:0]  cfg_height,
    input  logic [ADDR_WIDTH-1:0] cfg_in_base,
    input  logic [ADDR_WIDTH-1:0] cfg_out_base,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] pool_data,
    output logic                  pool_valid,
    output logic                  pool_last,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic                  res_valid,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            dbg_state
);

    localparam int WIN_W = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
    localparam int CNT_W = 2 * DIM_WIDTH;
    localparam logic [WIN_W-1:0]      WIN_LAST    = WIN_W'(WINDOW_SIZE - 1);
    localparam logic [DIM_WIDTH-1:0]  WIN_DIM     = DIM_WIDTH'(WINDOW_SIZE);
    localparam logic [DIM_WIDTH-1:0]  STRIDE_DIM  = DIM_WIDTH'(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_ADDR = ADDR_WIDTH'(STRIDE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_FIN   = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] width_q;
    logic [ADDR_WIDTH-1:0] row_step_q;
    logic [ADDR_WIDTH-1:0] out_base_q;
    logic [DIM_WIDTH-1:0]  ow_last_q;
    logic [DIM_WIDTH-1:0]  oh_last_q;
    logic [WIN_W-1:0]      dx, dy;
    logic [DIM_WIDTH-1:0]  ox, oy;
    logic [ADDR_WIDTH-1:0] col_base;
    logic [ADDR_WIDTH-1:0] row_addr;
    logic [ADDR_WIDTH-1:0] win_row_base;
    logic [CNT_W-1:0]      wr_cnt;
    logic [CNT_W-1:0]      win_cnt;
    logic                  pool_valid_q;
    logic                  pool_last_q;

    logic             idle_like;
    logic             cfg_ok;
    logic             accept;
    logic             last_read;
    logic [CNT_W-1:0] wr_cnt_next;

    // Width times stride as a chain of adds, so the address path stays multiplier-free.
    function automatic logic [ADDR_WIDTH-1:0] stride_rows(input logic [DIM_WIDTH-1:0] w);
        logic [ADDR_WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < STRIDE; i++) begin
            acc = acc + ADDR_WIDTH'(w);
        end
        return acc;
    endfunction

    // FIN and FAIL behave like IDLE for start acceptance, allowing back-to-back passes.
    assign idle_like   = (state == S_IDLE) || (state == S_FIN) || (state == S_FAIL);
    assign cfg_ok      = (cfg_width >= WIN_DIM) && (cfg_height >= WIN_DIM);
    assign accept      = start && idle_like;
    assign last_read   = (dx == WIN_LAST) && (dy == WIN_LAST) &&
                         (ox == ow_last_q) && (oy == oh_last_q);
    assign wr_cnt_next = wr_cnt + CNT_W'(res_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_FIN, S_FAIL: begin
                if (start) begin
                    state_next = cfg_ok ? S_ISSUE : S_FAIL;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (last_read) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (wr_cnt_next >= win_cnt) begin
                    state_next = S_FIN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy       = (state == S_ISSUE) || (state == S_DRAIN);
    assign done       = (state == S_FIN) || (state == S_FAIL);
    assign err        = (state == S_FAIL);
    assign rd_en      = (state == S_ISSUE);
    assign rd_addr    = rd_en ? (row_addr + col_base + ADDR_WIDTH'(dx)) : '0;
    assign pool_valid = pool_valid_q;
    assign pool_last  = pool_last_q;
    assign pool_data  = pool_valid_q ? rd_data : '0;
    assign wr_en      = busy && res_valid;
    assign wr_addr    = wr_en ? (out_base_q + ADDR_WIDTH'(wr_cnt)) : '0;
    assign wr_data    = wr_en ? res_data : '0;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            width_q      <= '0;
            row_step_q   <= '0;
            out_base_q   <= '0;
            ow_last_q    <= '0;
            oh_last_q    <= '0;
            dx           <= '0;
            dy           <= '0;
            ox           <= '0;
            oy           <= '0;
            col_base     <= '0;
            row_addr     <= '0;
            win_row_base <= '0;
            wr_cnt       <= '0;
            win_cnt      <= '0;
            pool_valid_q <= 1'b0;
            pool_last_q  <= 1'b0;
        end else begin
            pool_valid_q <= rd_en;
            pool_last_q  <= rd_en && last_read;
            if (accept) begin
                width_q      <= ADDR_WIDTH'(cfg_width);
                row_step_q   <= stride_rows(cfg_width);
                out_base_q   <= cfg_out_base;
                ow_last_q    <= (cfg_width - WIN_DIM) / STRIDE_DIM;
                oh_last_q    <= (cfg_height - WIN_DIM) / STRIDE_DIM;
                dx           <= '0;
                dy           <= '0;
                ox           <= '0;
                oy           <= '0;
                col_base     <= '0;
                row_addr     <= cfg_in_base;
                win_row_base <= cfg_in_base;
                wr_cnt       <= '0;
                win_cnt      <= '0;
            end else begin
                if (wr_en) begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                end
                if (rd_en) begin
                    // dx innermost, then dy, then ox, then oy.
                    if (dx != WIN_LAST) begin
                        dx <= dx + WIN_W'(1);
                    end else begin
                        dx <= '0;
                        if (dy != WIN_LAST) begin
                            dy       <= dy + WIN_W'(1);
                            row_addr <= row_addr + width_q;
                        end else begin
                            dy      <= '0;
                            win_cnt <= win_cnt + CNT_W'(1);
                            if (ox != ow_last_q) begin
                                ox       <= ox + DIM_WIDTH'(1);
                                col_base <= col_base + STRIDE_ADDR;
                                row_addr <= win_row_base;
                            end else begin
                                ox       <= '0;
                                col_base <= '0;
                                if (oy != oh_last_q) begin
                                    oy           <= oy + DIM_WIDTH'(1);
                                    win_row_base <= win_row_base + row_step_q;
                                    row_addr     <= win_row_base + row_step_q;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Bench for pool_window_sequencer: memory and pooling-unit models, expected-value
// queues for reads, samples and writes, plus directed and random pass scenarios.
module tb_pool_window_sequencer;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int DMW = 8;
    localparam int WS = 2;
    localparam int ST = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [DMW-1:0] cfg_width, cfg_height;
    logic [AW-1:0] cfg_in_base, cfg_out_base;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] pool_data;
    logic          pool_valid, pool_last;
    logic [DW-1:0] res_data;
    logic          res_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy, done, err;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    pool_window_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIM_WIDTH(DMW), .WINDOW_SIZE(WS), .STRIDE(ST)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pool_data(pool_data), .pool_valid(pool_valid), .pool_last(pool_last),
        .res_data(res_data), .res_valid(res_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    logic [AW-1:0]    rd_q[$];
    logic [DW:0]      pool_q[$];
    logic [AW+DW-1:0] wr_q[$];
    logic [DW-1:0]    res_pend[$];

    int            n_vec = 0;
    int            n_fail = 0;
    int            cycles = 0;
    int            n_rd = 0;
    int            n_wr = 0;
    int            n_done = 0;
    int            last_wr_cycle = 0;
    int            wr_k = 0;
    int            win_n = 0;
    logic [DW-1:0] win_max;
    logic [AW-1:0] last_rd_addr;
    logic [AW-1:0] rd_addr_s;
    logic [AW-1:0] cur_out_base;
    logic          have_rd = 1'b0;
    logic          stray_res = 1'b0;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    // Reference read order computed directly from the window formula.
    task automatic queue_pass(input int w, input int h, input logic [AW-1:0] in_base,
                              input logic [AW-1:0] out_base);
        int ow, oh, total, k;
        logic [AW-1:0] a;
        rd_q.delete(); pool_q.delete(); wr_q.delete(); res_pend.delete();
        ow = (w - WS) / ST + 1;
        oh = (h - WS) / ST + 1;
        total = ow * oh * WS * WS;
        k = 0;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int dy = 0; dy < WS; dy++)
                    for (int dx = 0; dx < WS; dx++) begin
                        a = AW'(int'(in_base) + (oy * ST + dy) * w + ox * ST + dx);
                        rd_q.push_back(a);
                        k++;
                        pool_q.push_back({(k == total), mem_val(a)});
                    end
        cur_out_base = out_base;
        wr_k = 0;
        win_n = 0;
    endtask

    task automatic kick(input int w, input int h, input logic [AW-1:0] in_base,
                        input logic [AW-1:0] out_base, input bit legal);
        cfg_width = DMW'(w);
        cfg_height = DMW'(h);
        cfg_in_base = in_base;
        cfg_out_base = out_base;
        start = 1'b1;
        if (legal) queue_pass(w, h, in_base, out_base);
    endtask

    // One clock: drive memory/pooling responses after the edge, observe at the falling edge.
    task automatic tick();
        logic [AW-1:0]    exp_a;
        logic [DW:0]      exp_p;
        logic [AW+DW-1:0] exp_w;
        @(posedge clk);
        #1;
        start = 1'b0;
        rd_data = have_rd ? mem_val(rd_addr_s) : DW'($urandom);
        if (stray_res) begin
            res_valid = 1'b1;
            res_data = DW'($urandom);
        end else if (res_pend.size() > 0 && $urandom_range(0, 3) != 0) begin
            res_valid = 1'b1;
            res_data = res_pend.pop_front();
            wr_q.push_back({AW'(cur_out_base + AW'(wr_k)), res_data});
            wr_k++;
        end else begin
            res_valid = 1'b0;
            res_data = '0;
        end
        @(negedge clk);
        cycles++;
        if (rd_en) begin
            n_rd++;
            n_vec++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: rd_addr=%h, no read required", rd_addr);
            end else begin
                exp_a = rd_q.pop_front();
                if (rd_addr !== exp_a) begin
                    n_fail++;
                    $display("FAIL rd_addr: got %h required %h", rd_addr, exp_a);
                end
            end
            have_rd = 1'b1;
            rd_addr_s = rd_addr;
            last_rd_addr = rd_addr;
        end else begin
            have_rd = 1'b0;
        end
        if (pool_valid) begin
            n_vec++;
            if (pool_q.size() == 0) begin
                n_fail++;
                $display("FAIL pool_unexpected: data=%h last=%b", pool_data, pool_last);
            end else begin
                exp_p = pool_q.pop_front();
                if ({pool_last, pool_data} !== exp_p) begin
                    n_fail++;
                    $display("FAIL pool_sample: got last=%b data=%h required last=%b data=%h",
                             pool_last, pool_data, exp_p[DW], exp_p[DW-1:0]);
                end
            end
            win_n++;
            win_max = (win_n == 1 || pool_data > win_max) ? pool_data : win_max;
            if (win_n == WS * WS) begin
                res_pend.push_back(win_max);
                win_n = 0;
            end
        end else if (pool_last) begin
            n_vec++;
            n_fail++;
            $display("FAIL pool_last_alone: pool_last=1 with pool_valid=0");
        end
        if (wr_en) begin
            n_wr++;
            n_vec++;
            last_wr_cycle = cycles;
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: addr=%h data=%h, no write required", wr_addr, wr_data);
            end else begin
                exp_w = wr_q.pop_front();
                if ({wr_addr, wr_data} !== exp_w) begin
                    n_fail++;
                    $display("FAIL wr: got addr=%h data=%h required addr=%h data=%h",
                             wr_addr, wr_data, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
                end
            end
        end
        if (done) n_done++;
    endtask

    task automatic run_to_done(input string name, input bit exp_err);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            tick();
            if (done) got = 1'b1;
        end
        n_vec++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_timeout: done=0 after 600 cycles, required done=1", name);
        end else begin
            n_vec++;
            if ({busy, err} !== {1'b0, exp_err}) begin
                n_fail++;
                $display("FAIL %s_flags: busy=%b err=%b required busy=0 err=%b", name, busy, err, exp_err);
            end
            n_vec++;
            if (rd_q.size() + pool_q.size() + wr_q.size() + res_pend.size() != 0) begin
                n_fail++;
                $display("FAIL %s_leftover: rd=%0d pool=%0d wr=%0d res=%0d required all 0", name,
                         rd_q.size(), pool_q.size(), wr_q.size(), res_pend.size());
            end
            if (!exp_err) begin
                n_vec++;
                if (cycles != last_wr_cycle + 1) begin
                    n_fail++;
                    $display("FAIL %s_done_latency: done at cycle %0d, required %0d", name, cycles,
                             last_wr_cycle + 1);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [105:0] outs;
        reset_n = 1'b0;
        stray_res = 1'b1;
        tick();
        tick();
        outs = {rd_en, pool_valid, pool_last, wr_en, busy, done, err,
                rd_addr, pool_data, wr_addr, wr_data, dbg_state};
        n_vec++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        stray_res = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_map_4x4();
        int r0 = n_rd;
        int w0 = n_wr;
        int d0 = n_done;
        kick(4, 4, 16'h0000, 16'h0200, 1'b1);
        tick();
        n_vec++;
        if ({busy, rd_en} !== 2'b11 || pool_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_latency: busy=%b rd_en=%b pool_valid=%b required 1 1 0", busy, rd_en, pool_valid);
        end
        tick();
        n_vec++;
        if (pool_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_pool_valid: got %b required 1", pool_valid);
        end
        run_to_done("map4x4", 1'b0);
        tick();
        n_vec++;
        if (done !== 1'b0 || n_done - d0 != 1) begin
            n_fail++;
            $display("FAIL map4x4_done_pulse: done=%b pulses=%0d required 0 and 1", done, n_done - d0);
        end
        n_vec++;
        if (n_rd - r0 != 16 || n_wr - w0 != 4) begin
            n_fail++;
            $display("FAIL map4x4_counts: reads=%0d writes=%0d required 16 4", n_rd - r0, n_wr - w0);
        end
    endtask

    task automatic test_map_5x5();
        int r0 = n_rd;
        kick(5, 5, 16'd100, 16'h0300, 1'b1);
        run_to_done("map5x5", 1'b0);
        n_vec++;
        if (last_rd_addr !== 16'd118 || n_rd - r0 != 16) begin
            n_fail++;
            $display("FAIL map5x5_last_read: addr=%0d reads=%0d required 118 16", last_rd_addr, n_rd - r0);
        end
    endtask

    task automatic test_illegal();
        int tw[3];
        int th[3];
        tw = '{1, 4, 0};
        th = '{4, 1, 5};
        for (int t = 0; t < 3; t++) begin
            int r0 = n_rd;
            int w0 = n_wr;
            kick(tw[t], th[t], 16'h0040, 16'h0080, 1'b0);
            tick();
            n_vec++;
            if ({done, err, busy} !== 3'b110) begin
                n_fail++;
                $display("FAIL illegal_%0dx%0d: done=%b err=%b busy=%b required 1 1 0", tw[t], th[t], done, err, busy);
            end
            tick();
            tick();
            n_vec++;
            if (done !== 1'b0 || n_rd != r0 || n_wr != w0) begin
                n_fail++;
                $display("FAIL illegal_%0dx%0d_quiet: done=%b reads=%0d writes=%0d required 0 0 0",
                         tw[t], th[t], done, n_rd - r0, n_wr - w0);
            end
        end
    endtask

    task automatic test_midpass_start();
        int d0 = n_done;
        kick(4, 4, 16'h0010, 16'h0400, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        kick(6, 6, 16'h0900, 16'h0500, 1'b0);
        run_to_done("midpass", 1'b0);
        for (int i = 0; i < 4; i++) tick();
        n_vec++;
        if (n_done - d0 != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midpass_single_done: pulses=%0d busy=%b required 1 0", n_done - d0, busy);
        end
    endtask

    task automatic test_reset_midpass();
        logic [105:0] outs;
        int r0 = n_rd;
        int d0;
        kick(4, 4, 16'h0020, 16'h0600, 1'b1);
        for (int i = 0; i < 40 && n_rd - r0 < 7; i++) tick();
        n_vec++;
        if (n_rd - r0 != 7) begin
            n_fail++;
            $display("FAIL rstmid_reads: got %0d reads required 7", n_rd - r0);
        end
        d0 = n_done;
        #2;
        reset_n = 1'b0;
        #1;
        outs = {rd_en, pool_valid, pool_last, wr_en, busy, done, err,
                rd_addr, pool_data, wr_addr, wr_data, dbg_state};
        n_vec++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async_clear: got %h required 0", outs);
        end
        rd_q.delete(); pool_q.delete(); wr_q.delete(); res_pend.delete();
        win_n = 0;
        have_rd = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        n_vec++;
        if (n_done != d0 || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: pulses=%0d state=%0d required 0 0", n_done - d0, dbg_state);
        end
        kick(4, 4, 16'h0020, 16'h0600, 1'b1);
        run_to_done("rstmid_restart", 1'b0);
    endtask

    task automatic test_wrap();
        kick(4, 4, 16'hFFFE, 16'hFFFE, 1'b1);
        run_to_done("wrap", 1'b0);
    endtask

    task automatic test_idle_result();
        int w0 = n_wr;
        stray_res = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        stray_res = 1'b0;
        tick();
        n_vec++;
        if (n_wr != w0) begin
            n_fail++;
            $display("FAIL idle_result: writes=%0d required 0", n_wr - w0);
        end
    endtask

    task automatic test_back_to_back();
        kick(6, 4, 16'h0050, 16'h0700, 1'b1);
        run_to_done("b2b_first", 1'b0);
        kick(4, 6, 16'h0080, 16'h0780, 1'b1);
        tick();
        n_vec++;
        if ({busy, rd_en} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b rd_en=%b required 1 1", busy, rd_en);
        end
        run_to_done("b2b_second", 1'b0);
    endtask

    task automatic test_random_maps();
        for (int t = 0; t < 6; t++) begin
            int w = $urandom_range(2, 9);
            int h = $urandom_range(2, 9);
            kick(w, h, AW'($urandom_range(0, 16'hFFFF)), AW'($urandom_range(0, 16'hFFFF)), 1'b1);
            run_to_done($sformatf("rand_%0dx%0d", w, h), 1'b0);
            tick();
        end
    endtask

    initial begin
        start = 1'b0;
        res_valid = 1'b0;
        res_data = '0;
        rd_data = '0;
        cfg_width = '0;
        cfg_height = '0;
        cfg_in_base = '0;
        cfg_out_base = '0;
        reset_n = 1'b0;
        test_reset();
        test_map_4x4();
        test_map_5x5();
        test_illegal();
        test_midpass_start();
        test_reset_midpass();
        test_wrap();
        test_idle_result();
        test_back_to_back();
        test_random_maps();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
